memory_scan_sequencer: RTL and testbench
========================================

// Module: memory_scan_sequencer
// PURPOSE
// - Shares one 16-word read-only memory between two requesters.
// - Each requester asks for a scan over an address range. The block arbitrates round-robin,
//   drives the memory address and read-enable, and returns the read data tagged with the owner.
// - Replaces the free-running one-shot address counter on the memory side.
// - Sits between requesting datapath blocks and the memory macro.
// PARAMETERS
// - ADDR_WIDTH    4  memory address width; scan wraps modulo 2**ADDR_WIDTH
// - DATA_WIDTH    8  memory word width
// - READ_LATENCY  1  cycles from address+readEnable to valid memDataSequencer; legal 1..3
// PORTS
// - clockSequencer      in   1             single clock; all state updates on posedge
// - resetSequencer      in   1             asynchronous, active-low reset
// - reqSequencer        in   2             per-requester scan request; level, sampled only in IDLE
// - startAddrSequencer  in   2*ADDR_WIDTH  first address; [AW-1:0]=req0, [2AW-1:AW]=req1
// - lastAddrSequencer   in   2*ADDR_WIDTH  last address, same packing
// - abortSequencer      in   1             synchronous abort of the current scan
// - memDataSequencer    in   DATA_WIDTH    memory read data
// - ackSequencer        out  2             one-cycle grant pulse; range captured on that edge
// - addressSequencer    out  ADDR_WIDTH    memory address
// - readEnableSequencer out  1             memory read strobe
// - dataOutSequencer    out  DATA_WIDTH    = memDataSequencer (combinational pass-through)
// - dataValidSequencer  out  1             dataOutSequencer holds a scan word this cycle
// - dataOwnerSequencer  out  1             requester index owning the valid word
// - doneSequencer       out  2             one-cycle pulse, concurrent with the owner's last valid beat
// - busySequencer       out  1             high in SCAN or DRAIN
// BEHAVIOUR
// - Reset (async, low):
//   - all outputs 0; state IDLE; validPipe cleared.
//   - lastGrant=1, so requester 0 wins the first tie.
//   - Reset mid-scan discards the scan; no done pulse.
// - FSM states: IDLE, SCAN, DRAIN. All outputs except dataOutSequencer are registered.
// - IDLE, any req high at edge E0:
//   - Winner = sole requester; if both request, the one != lastGrant.
//   - At E0: ack[w]=1 for one cycle, owner=w, lastGrant=w.
//   - At E0: address=start[w], readEnable=1, state=SCAN.
// - SCAN, each edge:
//   - If abort: go to IDLE (see abort rule).
//   - Else if address==lastCaptured: readEnable=0, state=DRAIN.
//   - Else: address=address+1, wrapping (2**AW-1)->0.
//   - Scan length = ((last-start) mod 2**AW)+1, range 1..16; start==last gives exactly one read.
// - Read data timing:
//   - validPipe is readEnable delayed READ_LATENCY cycles; dataValid = validPipe output.
//   - dataValid goes high READ_LATENCY cycles after readEnable, one beat per address, in order, no gaps.
// - DRAIN:
//   - Waits for the final beat. doneSequencer[owner] pulses on that beat; state=IDLE on the same edge.
//   - Next grant is possible on the following edge.
// - abort, in SCAN or DRAIN:
//   - Next edge: readEnable=0, validPipe flushed (no further dataValid), state=IDLE.
//   - No done pulse; lastGrant is kept. abort in IDLE is ignored.
// - Request handling:
//   - Changes to req or address inputs after ack are ignored until IDLE.
//   - A req still high after done is a new request; the other requester wins if it is also requesting.
// - busy=1 from the ack edge until the edge that returns to IDLE.
// STRUCTURE
// - Package sequencer_pkg holds:
//   - state encoding (IDLE=2'd0, SCAN=2'd1, DRAIN=2'd2)
//   - REQ_COUNT=2 and the helper packing/slicing macros for the per-requester address buses.
// - Sub-module rr_arbiter2 (2-way round-robin: req[1:0], lastGrant -> grantValid, grantIdx).
//   It is combinational; the lastGrant register stays in the sequencer.
// - Top level holds: FSM, address counter, captured lastAddr, validPipe shift register, done generation.
// TESTING (READ_LATENCY=1, memory model mem[i]=8'h10+i)
// - Reset release, req=2'b01, start0=3, last0=6:
//   - ack0 pulses; addresses 3,4,5,6.
//   - dataOut 13,14,15,16, valid on 4 consecutive cycles.
//   - done0 pulses with the 16 beat; busy then falls.
// - Wrap: start1=14, last1=1 -> addresses 14,15,0,1; 4 beats 1E,1F,10,11 with owner=1; done1 once.
// - Single word: start0=last0=9 -> one readEnable cycle, one beat 19, done0 on that beat.
// - Arbitration: req=2'b11 held continuously:
//   - grants alternate 0,1,0,1; exactly one ack per scan; owner matches ack on every beat.
// - Abort after the 2nd address of a 0..15 scan:
//   - readEnable drops next cycle; no valid beats after flush; no done; IDLE.
//   - Next req=2'b11 is granted to requester 1.
// - Reset asserted mid-scan (async, between edges):
//   - All outputs 0 immediately.
//   - After release, req=2'b11 grants requester 0 first.

Source files
------------

// File: rtl/memory_scan_sequencer_pkg.sv
// Shared definitions for the memory scan sequencer: FSM encoding, requester
// count and the helper that locates a requester's slice in a packed address bus.
package sequencer_pkg;

  localparam int REQ_COUNT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } seqState_t;

  // Per-requester address buses are packed with requester 0 in the low slice.
  function automatic int addrSliceLsb(input logic idx, input int aw);
    return idx ? aw : 0;
  endfunction

endpackage

// File: rtl/memory_scan_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter; purely combinational, the lastGrant history
// register lives in the sequencer.
module rr_arbiter2
  import sequencer_pkg::*;
(
  input  logic [REQ_COUNT-1:0] req,
  input  logic                 lastGrant,
  output logic                 grantValid,
  output logic                 grantIdx
);

  always_comb begin
    grantValid = |req;
    grantIdx   = 1'b0;
    unique case (req)
      2'b10:   grantIdx = 1'b1;
      2'b11:   grantIdx = ~lastGrant;
      default: grantIdx = 1'b0;
    endcase
  end

endmodule

// File: rtl/memory_scan_sequencer.sv
// Shares one read-only memory between two requesters: round-robin grant,
// address scan over the captured range, and owner-tagged read data return.
module memory_scan_sequencer
  import sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                            clockSequencer,
  input  logic                            resetSequencer,
  input  logic [REQ_COUNT-1:0]            reqSequencer,
  input  logic [REQ_COUNT*ADDR_WIDTH-1:0] startAddrSequencer,
  input  logic [REQ_COUNT*ADDR_WIDTH-1:0] lastAddrSequencer,
  input  logic                            abortSequencer,
  input  logic [DATA_WIDTH-1:0]           memDataSequencer,
  output logic [REQ_COUNT-1:0]            ackSequencer,
  output logic [ADDR_WIDTH-1:0]           addressSequencer,
  output logic                            readEnableSequencer,
  output logic [DATA_WIDTH-1:0]           dataOutSequencer,
  output logic                            dataValidSequencer,
  output logic                            dataOwnerSequencer,
  output logic [REQ_COUNT-1:0]            doneSequencer,
  output logic                            busySequencer
);

  // Request/ack handshake: req is a level held by the requester and is only
  // looked at in IDLE; ack pulses for exactly one cycle on the edge that
  // captures that requester's range. Later input changes are ignored until IDLE.

  seqState_t               state, stateNext;
  logic [ADDR_WIDTH-1:0]   lastCaptured, lastCapturedNext, addressNext;
  logic [READ_LATENCY-1:0] validPipe, validPipeNext, pipeEarlier;
  logic [REQ_COUNT-1:0]    ackNext, doneNext;
  logic                    readEnableNext, ownerNext, busyNext;
  logic                    lastGrant, lastGrantNext;
  logic                    grantValid, grantIdx;
  logic                    scanActive, aborting;

  rr_arbiter2 u_arbiter (
    .req        (reqSequencer),
    .lastGrant  (lastGrant),
    .grantValid (grantValid),
    .grantIdx   (grantIdx)
  );

  assign scanActive         = (state == SCAN) || (state == DRAIN);
  assign aborting           = abortSequencer && scanActive;
  assign dataOutSequencer   = memDataSequencer;
  assign dataValidSequencer = validPipe[READ_LATENCY-1];

  always_ff @(posedge clockSequencer or negedge resetSequencer) begin
    if (!resetSequencer) state <= IDLE;
    else                 state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (grantValid) stateNext = SCAN;
      SCAN: begin
        if (abortSequencer)                         stateNext = IDLE;
        else if (addressSequencer == lastCaptured)  stateNext = DRAIN;
      end
      // The done register is high exactly on the final beat, so leave right after it.
      DRAIN:   if (abortSequencer || (|doneSequencer)) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    ackNext          = '0;
    doneNext         = '0;
    addressNext      = addressSequencer;
    lastCapturedNext = lastCaptured;
    readEnableNext   = readEnableSequencer;
    ownerNext        = dataOwnerSequencer;
    lastGrantNext    = lastGrant;
    validPipeNext    = '0;
    pipeEarlier      = '0;
    busyNext         = 1'b0;

    unique case (state)
      IDLE: begin
        if (grantValid) begin
          ackNext[grantIdx] = 1'b1;
          ownerNext         = grantIdx;
          lastGrantNext     = grantIdx;
          addressNext       = startAddrSequencer[addrSliceLsb(grantIdx, ADDR_WIDTH) +: ADDR_WIDTH];
          lastCapturedNext  = lastAddrSequencer[addrSliceLsb(grantIdx, ADDR_WIDTH) +: ADDR_WIDTH];
          readEnableNext    = 1'b1;
        end
      end
      SCAN: begin
        if (abortSequencer || (addressSequencer == lastCaptured)) readEnableNext = 1'b0;
        else addressNext = addressSequencer + 1'b1;
      end
      DRAIN:   readEnableNext = 1'b0;
      default: readEnableNext = 1'b0;
    endcase

    if (!aborting) begin
      validPipeNext[0] = readEnableSequencer;
      for (int i = 1; i < READ_LATENCY; i++) validPipeNext[i] = validPipe[i-1];
    end

    // Final beat: the pipe output is about to carry a word and nothing follows it.
    pipeEarlier                   = validPipeNext;
    pipeEarlier[READ_LATENCY-1]   = 1'b0;
    if (validPipeNext[READ_LATENCY-1] && !(|pipeEarlier) && !readEnableNext)
      doneNext[dataOwnerSequencer] = 1'b1;

    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge clockSequencer or negedge resetSequencer) begin
    if (!resetSequencer) begin
      ackSequencer        <= '0;
      addressSequencer    <= '0;
      readEnableSequencer <= 1'b0;
      dataOwnerSequencer  <= 1'b0;
      doneSequencer       <= '0;
      busySequencer       <= 1'b0;
      lastCaptured        <= '0;
      validPipe           <= '0;
      lastGrant           <= 1'b1;
    end else begin
      ackSequencer        <= ackNext;
      addressSequencer    <= addressNext;
      readEnableSequencer <= readEnableNext;
      dataOwnerSequencer  <= ownerNext;
      doneSequencer       <= doneNext;
      busySequencer       <= busyNext;
      lastCaptured        <= lastCapturedNext;
      validPipe           <= validPipeNext;
      lastGrant           <= lastGrantNext;
    end
  end

endmodule

// File: tb/tb_memory_scan_sequencer.sv
// Bench for memory_scan_sequencer: directed vector table, hand-written abort,
// arbitration and reset sequences, and random traffic against a transaction model.
module tb_memory_scan_sequencer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RL = 1;
  localparam int W  = 9;

  typedef struct {
    logic [1:0] req;
    logic [3:0] start0, last0, start1, last1;
    logic       expOwner;
    int         expLen;
    logic [7:0] expFirst, expLast;
  } vec_t;

  logic          clk, rst_n;
  logic [1:0]    req;
  logic [7:0]    startAddr, lastAddr;
  logic          abort;
  logic [DW-1:0] memData;
  logic [1:0]    ackSequencer, doneSequencer;
  logic [AW-1:0] addressSequencer;
  logic          readEnableSequencer, dataValidSequencer, dataOwnerSequencer, busySequencer;
  logic [DW-1:0] dataOutSequencer;

  int checkCount = 0;
  int passCount  = 0;

  memory_scan_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clockSequencer      (clk),
    .resetSequencer      (rst_n),
    .reqSequencer        (req),
    .startAddrSequencer  (startAddr),
    .lastAddrSequencer   (lastAddr),
    .abortSequencer      (abort),
    .memDataSequencer    (memData),
    .ackSequencer        (ackSequencer),
    .addressSequencer    (addressSequencer),
    .readEnableSequencer (readEnableSequencer),
    .dataOutSequencer    (dataOutSequencer),
    .dataValidSequencer  (dataValidSequencer),
    .dataOwnerSequencer  (dataOwnerSequencer),
    .doneSequencer       (doneSequencer),
    .busySequencer       (busySequencer)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'(16 + i);
  always @(posedge clk) if (readEnableSequencer) memData <= mem[addressSequencer];

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [1:0] reqAtEdge;
  logic [7:0] startAtEdge, lastAtEdge;
  logic       abortAtEdge, rstAtEdge;
  always @(posedge clk) begin
    reqAtEdge   = req;
    startAtEdge = startAddr;
    lastAtEdge  = lastAddr;
    abortAtEdge = abort;
    rstAtEdge   = rst_n;
  end

  logic [W-1:0] exp_q[$];
  int   mState;            // 0 idle, 1 scan in flight, 2 final beat seen
  logic mLastGrant;
  int   mStart, scanLen, issued, sinceAck;
  int   scanBeats;
  logic [7:0] scanFirst, scanLast;
  logic lastAckOwner;

  always @(negedge clk) begin : monitor
    logic [1:0]   expAck;
    logic [W-1:0] e;
    logic         w;
    int           s, l;
    if (!rst_n || !rstAtEdge) begin
      check("rst_ack", ackSequencer, 0);
      check("rst_addr", addressSequencer, 0);
      check("rst_re", readEnableSequencer, 0);
      check("rst_valid", dataValidSequencer, 0);
      check("rst_owner", dataOwnerSequencer, 0);
      check("rst_done", doneSequencer, 0);
      check("rst_busy", busySequencer, 0);
      mState = 0; exp_q.delete(); mLastGrant = 1'b1; issued = 0; scanLen = 0;
    end else begin
      expAck = 2'b00;
      if (mState == 0) begin
        if (reqAtEdge != 2'b00) begin
          w = (reqAtEdge == 2'b11) ? ~mLastGrant : reqAtEdge[1];
          mLastGrant = w;
          expAck = w ? 2'b10 : 2'b01;
          s = w ? int'(startAtEdge[7:4]) : int'(startAtEdge[3:0]);
          l = w ? int'(lastAtEdge[7:4])  : int'(lastAtEdge[3:0]);
          scanLen = ((l - s + 16) % 16) + 1;
          for (int k = 0; k < scanLen; k++) exp_q.push_back({w, 8'(16 + ((s + k) % 16))});
          mStart = s; issued = 0; sinceAck = 0; mState = 1;
          scanBeats = 0; lastAckOwner = ackSequencer[1];
        end
      end else if (abortAtEdge) begin
        mState = 0; exp_q.delete(); issued = scanLen;
      end else if (mState == 2) begin
        mState = 0;
      end else begin
        sinceAck++;
      end

      check("ack", ackSequencer, expAck);
      if (mState == 1 && issued < scanLen) begin
        check("re", readEnableSequencer, 1);
        check("addr", addressSequencer, (mStart + issued) % 16);
        issued++;
      end else begin
        check("re", readEnableSequencer, 0);
      end

      if (mState == 1 && sinceAck >= RL && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid", dataValidSequencer, 1);
        check("data", dataOutSequencer, e[7:0]);
        check("owner", dataOwnerSequencer, e[8]);
        if (scanBeats == 0) scanFirst = dataOutSequencer;
        scanLast = dataOutSequencer;
        scanBeats++;
        if (exp_q.size() == 0) begin
          check("done_last", doneSequencer, e[8] ? 2'b10 : 2'b01);
          mState = 2;
        end else begin
          check("done_mid", doneSequencer, 0);
        end
      end else begin
        check("valid_idle", dataValidSequencer, 0);
        check("done_idle", doneSequencer, 0);
      end
      check("busy", busySequencer, (mState != 0) ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  // which: 0 = ack seen, 1 = done seen, 2 = busy low
  task automatic waitFor(input int which, input int budget, input string tag);
    bit got;
    got = 0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (which == 0 && ackSequencer != 2'b00) got = 1;
      if (which == 1 && doneSequencer != 2'b00) got = 1;
      if (which == 2 && !busySequencer) got = 1;
    end
    if (!got) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    @(posedge clk); #1;
    req = v.req; startAddr = {v.start1, v.start0}; lastAddr = {v.last1, v.last0};
    waitFor(0, 20, {tag, "_ack"});
    @(posedge clk); #1;
    req = 2'b00; startAddr = 8'($urandom); lastAddr = 8'($urandom);
    waitFor(1, 60, {tag, "_done"});
    @(posedge clk); #1;
    check({tag, "_grant"}, lastAckOwner, v.expOwner);
    check({tag, "_beats"}, scanBeats, v.expLen);
    check({tag, "_first"}, scanFirst, v.expFirst);
    check({tag, "_last"}, scanLast, v.expLast);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  logic grants[4];
  int   n;

  initial begin
    vecs[0] = '{2'b01, 4'd3,  4'd6,  4'd0,  4'd0,  1'b0, 4,  8'h13, 8'h16};
    vecs[1] = '{2'b10, 4'd0,  4'd0,  4'd14, 4'd1,  1'b1, 4,  8'h1E, 8'h11};
    vecs[2] = '{2'b01, 4'd9,  4'd9,  4'd0,  4'd0,  1'b0, 1,  8'h19, 8'h19};
    vecs[3] = '{2'b11, 4'd0,  4'd15, 4'd5,  4'd5,  1'b1, 1,  8'h15, 8'h15};
    vecs[4] = '{2'b11, 4'd0,  4'd15, 4'd5,  4'd5,  1'b0, 16, 8'h10, 8'h1F};
    vecs[5] = '{2'b10, 4'd0,  4'd0,  4'd15, 4'd14, 1'b1, 16, 8'h1F, 8'h1E};

    rst_n = 1'b1; req = 2'b00; startAddr = 8'h00; lastAddr = 8'h00; abort = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Both requesting continuously: grants alternate starting with requester 0.
    @(posedge clk); #1;
    req = 2'b11; startAddr = 8'h20; lastAddr = 8'h31;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge clk);
      if (ackSequencer != 2'b00) begin
        grants[n] = ackSequencer[1];
        n++;
      end
    end
    @(posedge clk); #1;
    req = 2'b00;
    check("arb_count", n, 4);
    for (int i = 0; i < n; i++) check($sformatf("arb_grant%0d", i), grants[i], i % 2);
    waitFor(2, 40, "arb_idle");

    // Abort a full-range scan after its second address.
    @(posedge clk); #1;
    req = 2'b01; startAddr = 8'h00; lastAddr = 8'h0F;
    waitFor(0, 20, "abort_ack");
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    check("abort_second_addr", addressSequencer, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_re", readEnableSequencer, 0);
    check("abort_busy", busySequencer, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_valid", dataValidSequencer, 0);
      check("abort_no_done", doneSequencer, 0);
    end
    runVector('{2'b11, 4'd2, 4'd3, 4'd7, 4'd8, 1'b1, 2, 8'h17, 8'h18}, "after_abort");

    // Asynchronous reset in the middle of a scan.
    @(posedge clk); #1;
    req = 2'b10; startAddr = 8'h00; lastAddr = 8'hF0;
    waitFor(0, 20, "rstmid_ack");
    @(posedge clk); #1;
    req = 2'b00;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rstmid_ack", ackSequencer, 0);
    check("rstmid_addr", addressSequencer, 0);
    check("rstmid_re", readEnableSequencer, 0);
    check("rstmid_valid", dataValidSequencer, 0);
    check("rstmid_owner", dataOwnerSequencer, 0);
    check("rstmid_done", doneSequencer, 0);
    check("rstmid_busy", busySequencer, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    runVector('{2'b11, 4'd5, 4'd6, 4'd9, 4'd9, 1'b0, 2, 8'h15, 8'h16}, "after_reset");

    // Random traffic, every cycle checked by the monitor.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      req       = 2'($urandom_range(0, 3));
      startAddr = 8'($urandom);
      lastAddr  = 8'($urandom);
      abort     = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk); #1;
    req = 2'b00; abort = 1'b0;
    waitFor(2, 60, "rand_idle");
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
